// File: rtl/add_seq_master.sv
// ---------------------------------------------------------------------------
// add_seq_master
//   Requester side of the nibble-adder en/ready handshake. Latches A, B and
//   the add/sub select, then drives one 4-bit adder one nibble at a time,
//   LSB first. Each nibble's carry-out feeds the next nibble's carry-in. The
//   assembled result, final carry and signed overflow are reported with a
//   one-cycle done pulse.
//
//   Optional feature macro: ADD_SEQ_TIMEOUT_EN
//     When defined, a per-request watchdog aborts a request that has waited
//     TIMEOUT cycles for add_ready. The abort sets err, pulses done and
//     returns result=0, carry=0, ovf=0. When undefined, err is tied to 0.
//
// Ports
//   i_clk, i_reset        clock (rising edge), async active-high reset
//   i_start, i_a, i_b,    operation request; sampled only while idle
//   i_sub                 1 = A-B, 0 = A+B
//   o_add_en, o_add_a,    request to the adder: nibble k of A and of B
//   o_add_b, o_add_cin    (B already inverted for sub), plus running carry
//   i_add_sum, i_add_cout adder response
//   i_add_ready           adder response valid
//   o_result, o_carry,    final values, valid from done until next start
//   o_ovf
//   o_busy, o_done, o_err status
// ---------------------------------------------------------------------------
module add_seq_master #(
  parameter int NIBBLES = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  input  logic                   i_sub,
  output logic                   o_add_en,
  output logic [3:0]             o_add_a,
  output logic [3:0]             o_add_b,
  output logic                   o_add_cin,
  input  logic [3:0]             i_add_sum,
  input  logic                   i_add_cout,
  input  logic                   i_add_ready,
  output logic [4*NIBBLES-1:0]   o_result,
  output logic                   o_carry,
  output logic                   o_ovf,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (NIBBLES < 1 || NIBBLES > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("add_seq_master: illegal NIBBLES/TIMEOUT");
  end

  logic [1:0]               r_state;
  logic [NIBBLES-1:0][3:0]  r_a;
  logic [NIBBLES-1:0][3:0]  r_b;      // stored pre-inverted for subtraction
  logic [NIBBLES-1:0][3:0]  r_res;
  logic [KW-1:0]            r_k;
  logic                     r_c;      // running carry between nibbles
  logic                     r_carry;
  logic                     r_ovf;

  logic w_req;
  logic w_accept;
  logic w_last;
  logic w_ovf;
  logic w_tmo;

  assign w_req    = (r_state == S_REQ);
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_k == KW'(NIBBLES - 1));

  // Carry into the MSB equals sum^a^b at bit 3 of the top nibble; r_c is
  // the carry out of the MSB once the last nibble has been captured.
  assign w_ovf = r_res[NIBBLES-1][3] ^ r_a[NIBBLES-1][3] ^ r_b[NIBBLES-1][3] ^ r_c;

`ifdef ADD_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] r_wd;
  logic           r_err;

  assign w_tmo = w_req && !i_add_ready && (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_req)            r_wd <= '0;
      else if (!i_add_ready) r_wd <= r_wd + 1'b1;

      if (w_accept)   r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_tmo = 1'b0;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_k     <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b ^ {W{i_sub}};
            r_c     <= i_sub;
            r_k     <= '0;
            r_res   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_add_ready) begin
            r_res[r_k] <= i_add_sum;
            r_c        <= i_add_cout;
            r_state    <= S_GAP;
          end else if (w_tmo) begin
            r_res   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_GAP: begin
          // one idle cycle so the adder drops ready before the next request
          if (w_last) begin
            r_carry <= r_c;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops the request at once.
  assign o_add_en  = w_req;
  assign o_add_a   = w_req ? r_a[r_k] : 4'h0;
  assign o_add_b   = w_req ? r_b[r_k] : 4'h0;
  assign o_add_cin = w_req & r_c;
  assign o_result  = r_res;
  assign o_carry   = r_carry;
  assign o_ovf     = r_ovf;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_add_seq_master.sv
module tb_add_seq_master;
  localparam int N = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         i_sub = 1'b0;
  logic         o_add_en, o_add_cin, add_cout, add_ready;
  logic [3:0]   o_add_a, o_add_b, add_sum;
  logic [W-1:0] o_result;
  logic         o_carry, o_ovf, o_busy, o_done, o_err;

  add_seq_master #(.NIBBLES(N), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .i_sub(i_sub), .o_add_en(o_add_en), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .o_add_cin(o_add_cin), .i_add_sum(add_sum), .i_add_cout(add_cout),
    .i_add_ready(add_ready), .o_result(o_result), .o_carry(o_carry),
    .o_ovf(o_ovf), .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- responder: 4-bit adder with en/ready -----------------
  // mode 0: ready 2 cycles after en rises; 1: random 5/0/7 plus noise on
  // ready while en is low; 2: never ready
  int   rsp_mode = 0, rsp_cnt = 0, rsp_dly = 2;
  logic rsp_noise = 1'b0;
  int   dl[3] = '{5, 0, 7};
  logic [4:0] rsp_s;

  always @(posedge clk) begin
    if (o_add_en) rsp_cnt <= rsp_cnt + 1;
    else begin
      rsp_cnt <= 0;
      rsp_dly <= (rsp_mode == 1) ? dl[$urandom_range(0, 2)] : 2;
    end
    rsp_noise <= (rsp_mode == 1) ? 1'($urandom) : 1'b0;
  end
  assign add_ready = o_add_en ? (rsp_mode != 2 && rsp_cnt >= rsp_dly) : rsp_noise;
  assign rsp_s     = {1'b0, o_add_a} + {1'b0, o_add_b} + {4'b0, o_add_cin};
  assign add_sum   = rsp_s[3:0];
  assign add_cout  = rsp_s[4];

  // request pulse log: count of en rises and carry-in seen at each rise
  int   en_pulses = 0;
  logic en_q = 1'b0;
  logic cin_log[$];
  always @(negedge clk) begin
    if (o_add_en && !en_q) begin
      en_pulses <= en_pulses + 1;
      cin_log.push_back(o_add_cin);
    end
    en_q <= o_add_en;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] res;
    logic c, v, e;
    int   dcyc;          // expected cycle of done, -1 = not checked
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, b, input logic s, input int dc);
    exp_t e;
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r  = s ? sa - sb : sa + sb;
    e.res  = r[W-1:0];
    e.c    = s ? (a >= b) : (int'(a) + int'(b) > 255);
    e.v    = (r < -128) || (r > 127);
    e.e    = 1'b0;
    e.dcyc = dc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && o_done) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", o_result, e.res);
        chk("carry", o_carry, e.c);
        chk("ovf", o_ovf, e.v);
        chk("err", o_err, e.e);
        if (e.dcyc >= 0) chk("done_cycle", cyc, e.dcyc);
      end
    end
  end

  // ---------------- driver tasks (entered and left at negedge) -----------
  task automatic do_op(input logic [W-1:0] a, b, input logic s, input int lat);
    int n = 0;
    while (o_busy && n < 200) begin @(negedge clk); n++; end
    if (o_busy) begin
      tests++; fails++;
      $display("FAIL busy_wait: got busy=1 expected idle within 200 cycles");
      return;
    end
    i_a = a; i_b = b; i_sub = s; i_start = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(model(a, b, s, (lat >= 0) ? cyc + lat : -1));
    i_start = 1'b0; i_a = W'($urandom); i_b = W'($urandom); i_sub = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || o_busy) && n < 500) begin @(negedge clk); n++; end
    if (sbq.size() != 0 || o_busy) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_p, e0;
    logic [W-1:0] ta, tb;
    logic ts;

    #1 reset = 1'b1;
    #1;
    chk("rst_add_en", o_add_en, 0);
    chk("rst_add_a", o_add_a, 0);
    chk("rst_add_b", o_add_b, 0);
    chk("rst_add_cin", o_add_cin, 0);
    chk("rst_result", o_result, 0);
    chk("rst_carry", o_carry, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic add, latency and carry chaining
    base_p = en_pulses;
    cin_log.delete();
    do_op(8'h3C, 8'h27, 1'b0, 8);
    wait_idle();
    chk("t1_en_pulses", en_pulses - base_p, 2);
    chk("t1_cin_count", cin_log.size(), 2);
    if (cin_log.size() == 2) begin
      chk("t1_cin0", cin_log[0], 0);
      chk("t1_cin1", cin_log[1], 1);
    end

    // 2: overflow, borrow, wraparound
    do_op(8'h7F, 8'h01, 1'b0, 8);
    do_op(8'h00, 8'h01, 1'b1, 8);
    do_op(8'hFF, 8'h01, 1'b0, 8);
    do_op(8'h80, 8'h01, 1'b1, 8);
    do_op(8'h55, 8'h55, 1'b1, 8);
    wait_idle();

    // 3: start held high 20 cycles with changing operands; accepts at
    // edge 0 and edge 10 (edge 9 is the DONE cycle, edge 10 is IDLE)
    e0 = 0;
    for (int i = 0; i < 20; i++) begin
      ta = W'($urandom); tb = W'($urandom); ts = 1'($urandom);
      i_a = ta; i_b = tb; i_sub = ts; i_start = 1'b1;
      @(posedge clk); #1;
      if (i == 0) e0 = cyc;
      if (i == 0 || i == 10) sbq.push_back(model(ta, tb, ts, e0 + i + 8));
      @(negedge clk);
    end
    i_start = 1'b0;
    wait_idle();

    // 4: reset during the second nibble request
    i_a = 8'h55; i_b = 8'h11; i_sub = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_en_before", o_add_en, 1);
    chk("t4_nibble1_a", o_add_a, 4'h5);
    chk("t4_partial", o_result, 8'h06);
    #2 reset = 1'b1;
    #1;
    chk("t4_en_async", o_add_en, 0);
    chk("t4_busy_async", o_busy, 0);
    chk("t4_result_async", o_result, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0, 8);
    wait_idle();

    // 5: random operands with random responder delays
    rsp_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    wait_idle();
    rsp_mode = 0;
    @(negedge clk); @(negedge clk);

`ifdef ADD_SEQ_TIMEOUT_EN
    // 6: responder never answers -> watchdog abort after 16 REQ cycles
    begin
      exp_t e;
      int n = 0;
      rsp_mode = 2;
      i_a = 8'h12; i_b = 8'h34; i_sub = 1'b0; i_start = 1'b1;
      @(posedge clk); #1;
      e.res = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b1; e.dcyc = cyc + 16;
      sbq.push_back(e);
      i_start = 1'b0;
      @(negedge clk);
      while (!o_done && n < 40) begin @(negedge clk); n++; end
      chk("t6_done_seen", o_done, 1);
      chk("t6_en_low", o_add_en, 0);
      @(negedge clk);
      chk("t6_err_held", o_err, 1);
      rsp_mode = 0;
      @(negedge clk);
      do_op(8'h20, 8'h22, 1'b0, 8);
      wait_idle();
      chk("t6_err_cleared", o_err, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
